// File: rtl/min_stream_reducer.sv
// min_stream_reducer: folds each valid/ready frame of unsigned words into its
// minimum, first index of that minimum and saturating beat count.
`timescale 1ns/1ps
`default_nettype none

module min_stream_reducer #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_min,
  output logic [CNT_W-1:0] out_idx,
  output logic [CNT_W-1:0] out_count,
  output logic             out_ovf
);

  typedef enum logic [0:0] {
    S_EMPTY = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_min_q, acc_min_d;
  logic [CNT_W-1:0] acc_idx_q, acc_idx_d;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic             acc_ovf_q, acc_ovf_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_min_q, out_min_d;
  logic [CNT_W-1:0] out_idx_q, out_idx_d;
  logic [CNT_W-1:0] out_count_q, out_count_d;
  logic             out_ovf_q, out_ovf_d;

  logic             w_accept;
  logic             w_lt;
  logic             w_sat;
  logic [WIDTH-1:0] w_min;
  logic [CNT_W-1:0] w_idx;
  logic [CNT_W-1:0] w_cnt;
  logic             w_ovf;

  // A pending result blocks the whole input so the accumulator never runs ahead.
  assign in_ready = ~out_valid_q | out_ready;
  assign w_accept = in_valid & in_ready;

  // Fold of the presented beat into the running frame state.
  always_comb begin
    w_lt  = in_data < acc_min_q;
    w_sat = acc_cnt_q == c_cnt_max;
    if (state_q == S_EMPTY) begin
      w_min = in_data;
      w_idx = '0;
      w_cnt = c_cnt_one;
      w_ovf = 1'b0;
    end else begin
      w_min = w_lt ? in_data : acc_min_q;
      w_idx = w_lt ? acc_cnt_q : acc_idx_q;
      w_cnt = w_sat ? c_cnt_max : acc_cnt_q + c_cnt_one;
      w_ovf = acc_ovf_q | w_sat;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_min_d   = acc_min_q;
    acc_idx_d   = acc_idx_q;
    acc_cnt_d   = acc_cnt_q;
    acc_ovf_d   = acc_ovf_q;
    out_valid_d = out_valid_q;
    out_min_d   = out_min_q;
    out_idx_d   = out_idx_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (w_accept) begin
      if (in_last) begin
        state_d     = S_EMPTY;
        out_valid_d = 1'b1;
        out_min_d   = w_min;
        out_idx_d   = w_idx;
        out_count_d = w_cnt;
        out_ovf_d   = w_ovf;
      end else begin
        state_d   = S_ACCUM;
        acc_min_d = w_min;
        acc_idx_d = w_idx;
        acc_cnt_d = w_cnt;
        acc_ovf_d = w_ovf;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_EMPTY;
      acc_min_q   <= '0;
      acc_idx_q   <= '0;
      acc_cnt_q   <= '0;
      acc_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_min_q   <= '0;
      out_idx_q   <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_min_q   <= acc_min_d;
      acc_idx_q   <= acc_idx_d;
      acc_cnt_q   <= acc_cnt_d;
      acc_ovf_q   <= acc_ovf_d;
      out_valid_q <= out_valid_d;
      out_min_q   <= out_min_d;
      out_idx_q   <= out_idx_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_min   = out_min_q;
  assign out_idx   = out_idx_q;
  assign out_count = out_count_q;
  assign out_ovf   = out_ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_min_stream_reducer.sv
// tb_min_stream_reducer: drives CNT_W=16 and CNT_W=4 instances with the same
// stream and checks both against a frame-level reference model.
`timescale 1ns/1ps
`default_nettype none

module tb_min_stream_reducer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b1;

  logic        in_ready16, out_valid16, out_ovf16;
  logic [31:0] out_min16;
  logic [15:0] out_idx16, out_count16;
  logic        in_ready4, out_valid4, out_ovf4;
  logic [31:0] out_min4;
  logic [3:0]  out_idx4, out_count4;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  min_stream_reducer #(.WIDTH(32), .CNT_W(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready16),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid16),
    .out_ready(out_ready), .out_min(out_min16), .out_idx(out_idx16),
    .out_count(out_count16), .out_ovf(out_ovf16));

  min_stream_reducer #(.WIDTH(32), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid4),
    .out_ready(out_ready), .out_min(out_min4), .out_idx(out_idx4),
    .out_count(out_count4), .out_ovf(out_ovf4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: whole-frame arithmetic over the accepted words.
  typedef struct {
    logic [31:0] mn;
    int          idx;
    int          cnt;
    bit          ovf;
  } res_t;

  logic [31:0] frame_q[$];
  res_t        got16[$];
  res_t        got4[$];
  bit          exp_valid = 1'b0;
  res_t        exp16, exp4;
  bit          m_acc = 1'b0;
  bit          chk_en = 1'b0;

  function automatic res_t ref_result(input int maxc);
    res_t r;
    int   fi;
    int   n;
    n    = frame_q.size();
    r.mn = frame_q[0];
    fi   = 0;
    for (int i = 1; i < n; i++) begin
      if (frame_q[i] < r.mn) begin
        r.mn = frame_q[i];
        fi   = i;
      end
    end
    r.cnt = (n > maxc) ? maxc : n;
    r.ovf = n > maxc;
    r.idx = (fi > maxc) ? maxc : fi;
    return r;
  endfunction

  always @(posedge clk) begin
    if (out_valid16 && out_ready && !rst)
      got16.push_back('{out_min16, int'(out_idx16), int'(out_count16), out_ovf16});
    if (out_valid4 && out_ready && !rst)
      got4.push_back('{out_min4, int'(out_idx4), int'(out_count4), out_ovf4});
    if (rst) begin
      frame_q.delete();
      exp_valid = 1'b0;
      exp16     = '{32'd0, 0, 0, 1'b0};
      exp4      = '{32'd0, 0, 0, 1'b0};
      m_acc     = 1'b0;
      chk_en    = 1'b1;
    end else begin
      m_acc = in_valid && (!exp_valid || out_ready);
      if (exp_valid && out_ready) exp_valid = 1'b0;
      if (m_acc) begin
        frame_q.push_back(in_data);
        if (in_last) begin
          exp16     = ref_result(65535);
          exp4      = ref_result(15);
          exp_valid = 1'b1;
          frame_q.delete();
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check("in_ready16", in_ready16, !exp_valid || out_ready);
      check("in_ready4", in_ready4, !exp_valid || out_ready);
      check("out_valid16", out_valid16, exp_valid);
      check("out_valid4", out_valid4, exp_valid);
      check("out_min16", out_min16, exp16.mn);
      check("out_idx16", out_idx16, exp16.idx);
      check("out_count16", out_count16, exp16.cnt);
      check("out_ovf16", out_ovf16, exp16.ovf);
      check("out_min4", out_min4, exp4.mn);
      check("out_idx4", out_idx4, exp4.idx);
      check("out_count4", out_count4, exp4.cnt);
      check("out_ovf4", out_ovf4, exp4.ovf);
    end
  end

  task automatic send(input logic [31:0] d, input logic l);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int k = 0; k < 64 && !done; k++) begin
      @(posedge clk);
      #2;
      if (m_acc) done = 1'b1;
    end
    in_valid = 1'b0;
    check("send_accepted", done, 1'b1);
  endtask

  task automatic idle(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic check_res(input string tag, input res_t g,
                           input logic [31:0] mn, input int idx, input int cnt, input bit ovf);
    check({tag, "_min"}, g.mn, mn);
    check({tag, "_idx"}, g.idx, idx);
    check({tag, "_cnt"}, g.cnt, cnt);
    check({tag, "_ovf"}, g.ovf, ovf);
  endtask

  initial begin
    logic [31:0] cur;
    int          beats_left;
    int          frames_done;
    int          cyc;

    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    idle(2);

    // Frame 7,3,9,3: tie keeps earlier index
    got16.delete(); got4.delete();
    send(32'd7, 1'b0); send(32'd3, 1'b0); send(32'd9, 1'b0); send(32'd3, 1'b1);
    idle(3);
    check("t1_n", got16.size(), 1);
    if (got16.size() >= 1) check_res("t1", got16[0], 32'd3, 1, 4, 1'b0);

    // Back-to-back single-beat frames
    got16.delete(); got4.delete();
    send(32'hFFFF_FFFF, 1'b1); send(32'h0, 1'b1);
    idle(3);
    check("t2_n", got16.size(), 2);
    if (got16.size() >= 2) begin
      check_res("t2a", got16[0], 32'hFFFF_FFFF, 0, 1, 1'b0);
      check_res("t2b", got16[1], 32'h0, 0, 1, 1'b0);
    end

    // Backpressure holds result and stalls the next frame
    got16.delete(); got4.delete();
    out_ready = 1'b0;
    send(32'd5, 1'b1);
    fork
      begin send(32'd2, 1'b0); send(32'd1, 1'b1); end
      begin repeat (4) @(posedge clk); #2; out_ready = 1'b1; end
    join
    idle(3);
    check("t3_n", got16.size(), 2);
    if (got16.size() >= 2) begin
      check_res("t3a", got16[0], 32'd5, 0, 1, 1'b0);
      check_res("t3b", got16[1], 32'd1, 1, 2, 1'b0);
    end

    // 17 descending beats: saturation on the CNT_W=4 instance
    got16.delete(); got4.delete();
    for (int i = 0; i < 17; i++) send(32'd100 - i, i == 16);
    idle(3);
    check("t4_n", got4.size(), 1);
    if (got4.size() >= 1) check_res("t4w4", got4[0], 32'd84, 15, 15, 1'b1);
    if (got16.size() >= 1) check_res("t4w16", got16[0], 32'd84, 16, 17, 1'b0);

    // Reset mid-frame discards the partial frame
    got16.delete(); got4.delete();
    send(32'd1, 1'b0); send(32'd2, 1'b0); send(32'd0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    send(32'd8, 1'b0); send(32'd4, 1'b1);
    idle(3);
    check("t5_n", got16.size(), 1);
    if (got16.size() >= 1) check_res("t5", got16[0], 32'd4, 1, 2, 1'b0);

    // Unsigned compare
    got16.delete(); got4.delete();
    send(32'h8000_0000, 1'b0); send(32'h7FFF_FFFF, 1'b1);
    idle(3);
    check("t6_n", got16.size(), 1);
    if (got16.size() >= 1) check_res("t6", got16[0], 32'h7FFF_FFFF, 1, 2, 1'b0);

    // Randomised frames with gaps and random backpressure
    frames_done = 0;
    beats_left  = $urandom_range(1, 20);
    cur         = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
    cyc         = 0;
    while (frames_done < 300 && cyc < 40000) begin
      if (m_acc) begin
        beats_left--;
        if (beats_left == 0) begin
          frames_done++;
          beats_left = $urandom_range(1, 20);
        end
        cur = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 7);
      end
      if (!(in_valid && !m_acc)) in_valid = ($urandom_range(0, 3) != 0);
      in_data   = cur;
      in_last   = (beats_left == 1);
      out_ready = ($urandom_range(0, 2) != 0);
      @(posedge clk);
      #2;
      cyc++;
    end
    check("rand_frames_done", frames_done, 300);
    idle(5);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
